// File: rtl/ext_mem_loader.sv
// ext_mem_loader: host burst loader and CPU/host data-memory arbiter.
// Optional read-back path enabled by defining `LOADER_READBACK_EN.
module ext_mem_loader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 8,
  parameter int ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_cmd_valid,
  output logic              host_cmd_ready,
  input  logic              host_cmd_write,
  input  logic [ADDR_W-1:0] host_cmd_addr,
  input  logic [LEN_W-1:0]  host_cmd_len,
  input  logic              host_wdata_valid,
  output logic              host_wdata_ready,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rdata_valid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_boot,
  output logic              cpu_reset,
  input  logic              cpu_MemWrite,
  input  logic [ADDR_W-1:0] cpu_DataAdr,
  input  logic [DATA_W-1:0] cpu_WriteData,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

`ifdef LOADER_READBACK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RUN   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RUN   = 2'd3
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  state_t            state;
  logic [ADDR_W-1:0] addrQ;
  logic [LEN_W-1:0]  cntQ;

  // Burst sequencer: command latch, per-word address/count step, boot hand-off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      addrQ <= '0;
      cntQ  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (host_cmd_valid) begin
            addrQ <= host_cmd_addr;
            cntQ  <= host_cmd_len;
            if (host_cmd_write) begin
              state <= WRITE;
            end else begin
`ifdef LOADER_READBACK_EN
              state <= READ;
`else
              state <= IDLE;
`endif
            end
          end else if (host_boot) begin
            state <= RUN;
          end
        end
        WRITE: begin
          if (host_wdata_valid) begin
            addrQ <= addrQ + STEP;
            cntQ  <= cntQ - 1'b1;
            if (cntQ == '0) state <= IDLE;
          end
        end
`ifdef LOADER_READBACK_EN
        READ: begin
          addrQ <= addrQ + STEP;
          cntQ  <= cntQ - 1'b1;
          if (cntQ == '0) state <= IDLE;
        end
`endif
        RUN: state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_READBACK_EN
  logic              rValidQ;
  logic [DATA_W-1:0] rDataQ;

  // Read-back register: one word per READ cycle, one clock behind its address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rValidQ <= 1'b0;
      rDataQ  <= '0;
    end else begin
      rValidQ <= (state == READ);
      if (state == READ) rDataQ <= mem_rdata;
    end
  end

  assign host_rdata_valid = rValidQ;
  assign host_rdata       = rDataQ;
  assign busy             = (state == WRITE) || (state == READ);
`else
  logic unusedRdata;
  assign unusedRdata      = ^mem_rdata;
  assign host_rdata_valid = 1'b0;
  assign host_rdata       = '0;
  assign busy             = (state == WRITE);
`endif

  assign host_cmd_ready   = (state == IDLE);
  assign host_wdata_ready = (state == WRITE);
  assign cpu_reset        = (state != RUN);

  // Memory port mux: host owns it until boot, the CPU owns it in RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addrQ;
    mem_wdata = '0;
    case (state)
      WRITE: begin
        mem_we    = host_wdata_valid;
        mem_wdata = host_wdata;
      end
      RUN: begin
        mem_we    = cpu_MemWrite;
        mem_addr  = cpu_DataAdr;
        mem_wdata = cpu_WriteData;
      end
      default: begin
        mem_we    = 1'b0;
        mem_addr  = addrQ;
        mem_wdata = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ext_mem_loader.sv
// tb_ext_mem_loader: directed bench for ext_mem_loader.
// Small word-addressed memory model backs the DUT memory port.
module tb_ext_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_cmd_valid;
  logic        host_cmd_ready;
  logic        host_cmd_write;
  logic [31:0] host_cmd_addr;
  logic [7:0]  host_cmd_len;
  logic        host_wdata_valid;
  logic        host_wdata_ready;
  logic [31:0] host_wdata;
  logic        host_rdata_valid;
  logic [31:0] host_rdata;
  logic        host_boot;
  logic        cpu_reset;
  logic        cpu_MemWrite;
  logic [31:0] cpu_DataAdr;
  logic [31:0] cpu_WriteData;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  logic [31:0] tbMem [0:255];
  int          nChecks = 0;
  int          nErrors = 0;

  always #5 clk = ~clk;

  ext_mem_loader dut (
    .clk              (clk),
    .reset            (reset),
    .host_cmd_valid   (host_cmd_valid),
    .host_cmd_ready   (host_cmd_ready),
    .host_cmd_write   (host_cmd_write),
    .host_cmd_addr    (host_cmd_addr),
    .host_cmd_len     (host_cmd_len),
    .host_wdata_valid (host_wdata_valid),
    .host_wdata_ready (host_wdata_ready),
    .host_wdata       (host_wdata),
    .host_rdata_valid (host_rdata_valid),
    .host_rdata       (host_rdata),
    .host_boot        (host_boot),
    .cpu_reset        (cpu_reset),
    .cpu_MemWrite     (cpu_MemWrite),
    .cpu_DataAdr      (cpu_DataAdr),
    .cpu_WriteData    (cpu_WriteData),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .busy             (busy)
  );

  assign mem_rdata = tbMem[mem_addr[9:2]];

  // Memory model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_we) tbMem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeBurst(input logic [31:0] a,
                            input logic [7:0]  len,
                            input logic [31:0] d0,
                            input bit          gap);
    host_cmd_valid = 1'b1;
    host_cmd_write = 1'b1;
    host_cmd_addr  = a;
    host_cmd_len   = len;
    #1;
    check("cmdReady", {31'd0, host_cmd_ready}, 32'd1);
    tick();
    host_cmd_valid = 1'b0;
    #1;
    check("wdataReady", {31'd0, host_wdata_ready}, 32'd1);
    check("busyW", {31'd0, busy}, 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      if (gap) begin
        host_wdata_valid = 1'b0;
        #1;
        check("weIdle", {31'd0, mem_we}, 32'd0);
        tick();
      end
      host_wdata_valid = 1'b1;
      host_wdata       = d0 + 32'(i);
      #1;
      check("we", {31'd0, mem_we}, 32'd1);
      check("wAddr", mem_addr, a + 32'(4 * i));
      check("wData", mem_wdata, d0 + 32'(i));
      check("cpuRstW", {31'd0, cpu_reset}, 32'd1);
      tick();
    end
    host_wdata_valid = 1'b0;
    #1;
    check("idleAfterW", {31'd0, host_cmd_ready}, 32'd1);
    check("busyEnd", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    foreach (tbMem[i]) tbMem[i] = 32'd0;
    reset            = 1'b1;
    host_cmd_valid   = 1'b0;
    host_cmd_write   = 1'b0;
    host_cmd_addr    = 32'd0;
    host_cmd_len     = 8'd0;
    host_wdata_valid = 1'b0;
    host_wdata       = 32'd0;
    host_boot        = 1'b0;
    cpu_MemWrite     = 1'b0;
    cpu_DataAdr      = 32'd0;
    cpu_WriteData    = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rstCmdReady", {31'd0, host_cmd_ready}, 32'd1);
    check("rstWReady", {31'd0, host_wdata_ready}, 32'd0);
    check("rstBusy", {31'd0, busy}, 32'd0);
    check("rstCpuReset", {31'd0, cpu_reset}, 32'd1);
    check("rstRValid", {31'd0, host_rdata_valid}, 32'd0);
    check("rstRData", host_rdata, 32'd0);
    check("rstMemWe", {31'd0, mem_we}, 32'd0);
    check("rstMemAddr", mem_addr, 32'd0);

    // Gapped write burst of four words.
    writeBurst(32'h100, 8'd3, 32'hA0, 1'b1);
    check("mem100", tbMem[64], 32'hA0);
    check("mem10C", tbMem[67], 32'hA3);

    // Read-back of the same four words.
    host_cmd_valid = 1'b1;
    host_cmd_write = 1'b0;
    host_cmd_addr  = 32'h100;
    host_cmd_len   = 8'd3;
    tick();
    host_cmd_valid = 1'b0;
    #1;
`ifdef LOADER_READBACK_EN
    check("rdFirstCycle", {31'd0, host_rdata_valid}, 32'd0);
    check("rdBusy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rdValid", {31'd0, host_rdata_valid}, 32'd1);
      check("rdData", host_rdata, 32'hA0 + 32'(i));
    end
    check("rdIdle", {31'd0, host_cmd_ready}, 32'd1);
    tick();
    check("rdValidEnd", {31'd0, host_rdata_valid}, 32'd0);
`else
    check("rdDiscard", {31'd0, host_cmd_ready}, 32'd1);
    check("rdNoBusy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rdNoValid", {31'd0, host_rdata_valid}, 32'd0);
      check("rdZero", host_rdata, 32'd0);
    end
`endif

    // Address wrap from the top of the space.
    writeBurst(32'hFFFF_FFFC, 8'd1, 32'hB0, 1'b0);
    check("memTop", tbMem[255], 32'hB0);
    check("memWrap", tbMem[0], 32'hB1);

    // Reset during the third word of an eight-word burst.
    host_cmd_valid = 1'b1;
    host_cmd_write = 1'b1;
    host_cmd_addr  = 32'h200;
    host_cmd_len   = 8'd7;
    tick();
    host_cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      host_wdata_valid = 1'b1;
      host_wdata       = 32'hC0 + 32'(i);
      tick();
    end
    host_wdata = 32'hC2;
    reset      = 1'b1;
    #1;
    check("abortWe", {31'd0, mem_we}, 32'd0);
    check("abortCpuRst", {31'd0, cpu_reset}, 32'd1);
    check("abortBusy", {31'd0, busy}, 32'd0);
    tick();
    reset            = 1'b0;
    host_wdata_valid = 1'b0;
    #1;
    check("abortW0", tbMem[128], 32'hC0);
    check("abortW1", tbMem[129], 32'hC1);
    check("abortW2", tbMem[130], 32'd0);
    check("abortIdle", {31'd0, host_cmd_ready}, 32'd1);
    check("abortRValid", {31'd0, host_rdata_valid}, 32'd0);
    check("abortAddr", mem_addr, 32'd0);

    // Command and boot together: command wins.
    host_boot      = 1'b1;
    host_cmd_valid = 1'b1;
    host_cmd_write = 1'b1;
    host_cmd_addr  = 32'h300;
    host_cmd_len   = 8'd0;
    tick();
    host_cmd_valid = 1'b0;
    #1;
    check("bootIgnored", {31'd0, cpu_reset}, 32'd1);
    check("bootCmdTaken", {31'd0, busy}, 32'd1);
    tick();
    check("bootNotKept", {31'd0, cpu_reset}, 32'd1);
    host_boot        = 1'b0;
    host_wdata_valid = 1'b1;
    host_wdata       = 32'hD0;
    #1;
    check("bootWe", {31'd0, mem_we}, 32'd1);
    tick();
    host_wdata_valid = 1'b0;
    host_boot        = 1'b1;
    #1;
    check("bootSampleCycle", {31'd0, cpu_reset}, 32'd1);
    tick();
    host_boot = 1'b0;
    #1;
    check("runCpuReset", {31'd0, cpu_reset}, 32'd0);
    check("runCmdReady", {31'd0, host_cmd_ready}, 32'd0);
    check("runWReady", {31'd0, host_wdata_ready}, 32'd0);
    check("runBusy", {31'd0, busy}, 32'd0);

    // CPU owns the memory port; host traffic is ignored.
    host_cmd_valid   = 1'b1;
    host_wdata_valid = 1'b1;
    host_wdata       = 32'hEE;
    cpu_MemWrite     = 1'b1;
    cpu_DataAdr      = 32'h20;
    cpu_WriteData    = 32'h55;
    #1;
    check("runWe", {31'd0, mem_we}, 32'd1);
    check("runAddr", mem_addr, 32'h20);
    check("runData", mem_wdata, 32'h55);
    check("runCmdBlock", {31'd0, host_cmd_ready}, 32'd0);
    tick();
    cpu_MemWrite = 1'b0;
    #1;
    check("runStore", tbMem[8], 32'h55);
    check("runWeFollow", {31'd0, mem_we}, 32'd0);
    check("runStay", {31'd0, cpu_reset}, 32'd0);
    host_cmd_valid   = 1'b0;
    host_wdata_valid = 1'b0;

    // Reset leaves RUN asynchronously.
    reset = 1'b1;
    #1;
    check("asyncCpuRst", {31'd0, cpu_reset}, 32'd1);
    tick();
    reset = 1'b0;
    #1;
    check("postRunIdle", {31'd0, host_cmd_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
